fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Keeps a byte-address PC, drives the word
//            index to instruction memory and registers the returned
//            instruction into the IF/ID pipeline register. Handles redirects
//            from execute, downstream stalls, and a terminal HALT instruction.
// Ports    :
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous active-high reset
//   stall         in   1   freeze PC and IF/ID register
//   branch_taken  in   1   redirect request (beats stall)
//   branch_target in  32   redirect byte address (low 2 bits dropped)
//   Ins           in  32   instruction word for PCAddr (combinational memory)
//   PCAddr        out 32   word index {2'b00, pc[31:2]}
//   IF_ID_PC      out 32   byte address of IF_ID_Ins
//   IF_ID_Ins     out 32   registered instruction
//   IF_ID_valid   out  1   IF_ID_Ins holds a real instruction
//   halted        out  1   fetch has stopped on HALT_INS
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013,
  parameter logic [31:0] HALT_INS = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] Ins,
  output logic [31:0] PCAddr,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Ins,
  output logic        IF_ID_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] r_if_ins;
  logic [31:0] w_if_ins_nxt;
  logic        r_if_valid;
  logic        w_if_valid_nxt;

  // State register: everything changes only here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_if_pc    <= 32'h0000_0000;
      r_if_ins   <= NOP_INS;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_ins   <= w_if_ins_nxt;
      r_if_valid <= w_if_valid_nxt;
    end
  end

  // Next-state logic. Defaults hold every register, so each branch only
  // lists what it changes.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_pc_nxt    = r_if_pc;
    w_if_ins_nxt   = r_if_ins;
    w_if_valid_nxt = r_if_valid;

    case (r_state)
      BOOT: begin
        // One dead cycle after reset; nothing is captured.
        w_state_nxt = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          // Redirect squashes whatever was being fetched this cycle.
          w_pc_nxt       = {branch_target[31:2], 2'b00};
          w_if_pc_nxt    = 32'h0000_0000;
          w_if_ins_nxt   = NOP_INS;
          w_if_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_if_pc_nxt    = r_pc;
          w_if_ins_nxt   = Ins;
          w_if_valid_nxt = 1'b1;
          if (Ins == HALT_INS) begin
            // The halt instruction is passed down, but fetch stops on it.
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt = r_pc + 32'd4;  // wraps naturally at 2^32
          end
        end
      end

      HALT: begin
        // Redirects are ignored; only reset leaves this state.
        if (!stall) begin
          w_if_ins_nxt   = NOP_INS;
          w_if_valid_nxt = 1'b0;
        end
      end

      default: begin
        // Unreachable encoding: restart cleanly through BOOT.
        w_state_nxt    = BOOT;
        w_pc_nxt       = RESET_PC;
        w_if_pc_nxt    = 32'h0000_0000;
        w_if_ins_nxt   = NOP_INS;
        w_if_valid_nxt = 1'b0;
      end
    endcase
  end

  assign PCAddr      = {2'b00, r_pc[31:2]};
  assign IF_ID_PC    = r_if_pc;
  assign IF_ID_Ins   = r_if_ins;
  assign IF_ID_valid = r_if_valid;
  assign halted      = (r_state == HALT);

endmodule
`default_nettype wire
